block_float_rounder: RTL and testbench
======================================

Name: block_float_rounder

Overview:
Multi-channel block-floating-point rounder. For each block of BLKLEN valid beats it measures the common headroom across all channels and samples. That headroom becomes the offset (shift of output MSB from input MSB) applied to every channel for the following block. Rounding is to nearest with saturation. The block sits between wide DSP accumulators/filters and narrower downstream datapaths, and reports the applied offset (block exponent) alongside the data.

Parameters:
IWIDTH, 16, input sample width per channel
OWIDTH, 10, output sample width per channel (OWIDTH < IWIDTH)
CHANNELS, 2, number of parallel channels sharing one offset
BLKLEN, 4, valid beats per block (>= 2)
SIGNREP, "SIGNED", "SIGNED" or "UNSIGNED" sample representation

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
auto_ena  input  1  1 = offset from headroom detection, 0 = manual offset
man_offset  input  OFFW  manual offset; OFFW = $clog2(IWIDTH-OWIDTH+1)
i_valid  input  1  input beat qualifier
i_data  input  CHANNELS*IWIDTH  channel c at bits [c*IWIDTH +: IWIDTH]
o_valid  output  1  output beat qualifier
o_sob  output  1  start of block, high with first output beat of each block
o_offset  output  OFFW  offset applied to the current output beat
o_data  output  CHANNELS*OWIDTH  channel c at bits [c*OWIDTH +: OWIDTH]

Behaviour:
- Reset: all outputs 0; beat counter 0; active offset 0; headroom accumulator = MAXOFF (IWIDTH-OWIDTH). Reset asserted mid-block discards the partial block and any in-flight beats.
- Beat counter advances only on i_valid, wraps BLKLEN-1 -> 0. Gaps in i_valid do not affect block state.
- Headroom per sample:
  - SIGNED: count of leading bits equal to the MSB, minus 1.
  - UNSIGNED: count of leading zeros.
  - Clip at MAXOFF. All-zero or all-one signed words give the full clip.
- Accumulator holds the minimum over all channels and all beats of the block. On the last beat (counter = BLKLEN-1) the final minimum, including that beat, is loaded into the active offset and the accumulator is re-armed to MAXOFF in the same cycle.
- The new offset applies from the next valid beat, which is the first beat of the next block. The first block after reset uses offset 0.
- Manual mode: when auto_ena=0, the value loaded at block end is min(man_offset, MAXOFF) instead of the measured headroom. auto_ena and man_offset are sampled only at block end.
- Datapath:
  - Stage 1 registers each sample shifted left by the active offset, zero-filled into IWIDTH bits.
  - Stage 2 rounds: add 2^(IWIDTH-OWIDTH-1), keep the top OWIDTH bits. This is round half up, toward +inf, for both representations.
  - On overflow, saturate: SIGNED to the maximum positive value, UNSIGNED to all ones.
  - Bits shifted out above the MSB are lost. This happens only when the current block's signal exceeds the previous block's range, or in manual mode.
- Latency is fixed at 2 cycles: o_valid, o_sob, o_offset and o_data correspond to the i_valid beat two cycles earlier. o_sob = 1 when that beat had counter 0. o_data holds its last value when o_valid=0.
- No back-pressure; every valid input beat is output.

Test Plan:
All scenarios use IWIDTH=16, OWIDTH=10, CHANNELS=2, BLKLEN=4, SIGNED, auto_ena=1, so MAXOFF=6.

- Saturation: after reset, block 0 with both channels 16'h7FFF -> o_offset=0, o_data channels 10'h1FF (saturated), o_sob on beat 0 only, latency 2 cycles.
- Positive headroom: block 0 with all samples 16'h00F0 (headroom 7, clipped 6); block 1 with 16'h00F0 -> block 1 outputs o_offset=6, o_data 10'h0F0.
- Negative headroom: block with 16'hFF00 and 16'h0004 -> next block o_offset=6; 16'hFF00 in that block -> 10'h300.
- Mixed channels: one beat with channel 1 = 16'h0400, all others 16'h0001 -> next offset 4; 16'h0400 -> 10'h100.
- Rounding at offset 0 (manual, man_offset=0):
  - 16'h0020 -> 10'h001
  - 16'h001F -> 10'h000
  - 16'hFFE0 -> 10'h000
  - 16'hFFDF -> 10'h3FF
- Stalls, manual clip and reset:
  - i_valid toggled every other cycle -> block boundaries still every 4 valid beats.
  - man_offset=7 with auto_ena=0 -> o_offset=6.
  - rst asserted at beat 2 -> o_valid drops immediately; next block starts at o_sob with o_offset=0.

Source files
------------

// File: rtl/block_float_rounder.sv
// block_float_rounder: block-floating-point rounder sharing one headroom-derived offset across channels
module block_float_rounder #(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 10,
  parameter int CHANNELS = 2,
  parameter int BLKLEN = 4,
  parameter SIGNREP = "SIGNED",
  localparam int OFFW = $clog2(IWIDTH - OWIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         auto_ena,
  input  logic [OFFW-1:0]              man_offset,
  input  logic                         i_valid,
  input  logic [CHANNELS*IWIDTH-1:0]   i_data,
  output logic                         o_valid,
  output logic                         o_sob,
  output logic [OFFW-1:0]              o_offset,
  output logic [CHANNELS*OWIDTH-1:0]   o_data
);
  localparam int MAXOFF = IWIDTH - OWIDTH;
  localparam bit SGN = (SIGNREP == "SIGNED");
  localparam int CW = $clog2(BLKLEN);
  localparam int TOP = SGN ? IWIDTH - 2 : IWIDTH - 1;
  localparam logic [OFFW-1:0] MAXO = OFFW'(MAXOFF);
  localparam logic [IWIDTH:0] HALF = (IWIDTH + 1)'(1) << (MAXOFF - 1);
  localparam logic [OWIDTH-1:0] SATV = {OWIDTH{1'b1}} >> SGN;

  // Run of bits below the sign (or from the top when unsigned) that match the sign, clipped at MAXOFF
  function automatic logic [OFFW-1:0] headroom(input logic [IWIDTH-1:0] x);
    logic run;
    logic [OFFW-1:0] h;
    run = 1'b1;
    h = '0;
    for (int k = 0; k < MAXOFF; k++) begin
      run = run & (x[TOP-k] == (SGN & x[IWIDTH-1]));
      h = h + OFFW'(run);
    end
    return h;
  endfunction

  logic [CW-1:0] cnt;
  logic [OFFW-1:0] off, acc, blk_min, man_clip;
  logic last;
  logic [CHANNELS-1:0][IWIDTH-1:0] din, s1_data;
  logic [CHANNELS-1:0][OFFW-1:0] hr;
  logic [CHANNELS-1:0][OWIDTH-1:0] rnd;
  logic s1_valid, s1_sob;
  logic [OFFW-1:0] s1_off;

  assign din = i_data;
  assign last = cnt == CW'(BLKLEN - 1);
  assign man_clip = man_offset > MAXO ? MAXO : man_offset;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [IWIDTH:0] sum;
    assign hr[g] = headroom(din[g]);
    assign sum = {1'b0, s1_data[g]} + HALF;
    assign rnd[g] = (SGN ? ~s1_data[g][IWIDTH-1] & sum[IWIDTH-1] : sum[IWIDTH]) ? SATV : sum[IWIDTH-1 -: OWIDTH];
  end

  // Running minimum headroom including the current beat
  always_comb begin
    blk_min = acc;
    for (int c = 0; c < CHANNELS; c++) blk_min = hr[c] < blk_min ? hr[c] : blk_min;
  end

  // Beat counter, headroom accumulator and offset update at block end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      off <= '0;
      acc <= MAXO;
    end else if (i_valid) begin
      cnt <= last ? '0 : cnt + 1'b1;
      acc <= last ? MAXO : blk_min;
      if (last) off <= auto_ena ? blk_min : man_clip;
    end
  end

  // Stage 1: normalise each sample by the active offset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sob <= 1'b0;
      s1_off <= '0;
      s1_data <= '0;
    end else begin
      s1_valid <= i_valid;
      s1_sob <= i_valid & (cnt == '0);
      if (i_valid) begin
        s1_off <= off;
        for (int c = 0; c < CHANNELS; c++) s1_data[c] <= din[c] << off;
      end
    end
  end

  // Stage 2: register rounded, saturated samples; data and offset hold between beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_sob <= 1'b0;
      o_offset <= '0;
      o_data <= '0;
    end else begin
      o_valid <= s1_valid;
      o_sob <= s1_valid & s1_sob;
      if (s1_valid) begin
        o_offset <= s1_off;
        o_data <= rnd;
      end
    end
  end
endmodule

// File: tb/tb_block_float_rounder.sv
// tb_block_float_rounder: scoreboard bench for block_float_rounder at 16->10 bits, 2 channels, blocks of 4
module tb_block_float_rounder;
  logic clk, rst, auto_ena, i_valid, o_valid, o_sob;
  logic [2:0] man_offset, o_offset;
  logic [31:0] i_data;
  logic [19:0] o_data;
  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic v;
    logic sob;
    logic [2:0] off;
    logic [19:0] data;
  } exp_t;
  exp_t q[$];

  block_float_rounder #(.IWIDTH(16), .OWIDTH(10), .CHANNELS(2), .BLKLEN(4), .SIGNREP("SIGNED")) dut (
    .clk(clk), .rst(rst), .auto_ena(auto_ena), .man_offset(man_offset), .i_valid(i_valid),
    .i_data(i_data), .o_valid(o_valid), .o_sob(o_sob), .o_offset(o_offset), .o_data(o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    auto_ena = 1'b1;
    man_offset = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic sob,
                      input logic [2:0] off, input logic [9:0] ea, input logic [9:0] eb);
    exp_t e;
    e.v = v;
    e.sob = v & sob;
    e.off = off;
    e.data = {eb, ea};
    i_valid = v;
    i_data = {b, a};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    i_data = '0;
    auto_ena = 1'b1;
    man_offset = 3'd0;
    @(posedge clk);
    #1;
    compared += 4;
    if (o_valid !== 1'b0) begin mismatched++; $display("FAIL reset o_valid: got %b want 0", o_valid); end
    if (o_sob !== 1'b0) begin mismatched++; $display("FAIL reset o_sob: got %b want 0", o_sob); end
    if (o_offset !== 3'd0) begin mismatched++; $display("FAIL reset o_offset: got %0d want 0", o_offset); end
    if (o_data !== 20'h0) begin mismatched++; $display("FAIL reset o_data: got %h want 00000", o_data); end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) step(1'b1, 16'h7FFF, 16'h7FFF, i == 0 || i == 4, 3'd0, 10'h1FF, 10'h1FF);
      else step(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 10'h0, 10'h0);
      if (q.size() > 1) begin
        e = q.pop_front();
        compared++;
        if (o_valid !== e.v || o_sob !== e.sob || (e.v && {o_offset, o_data} !== {e.off, e.data})) begin
          mismatched++;
          $display("FAIL saturation beat %0d: got v=%b sob=%b off=%0d data=%h want v=%b sob=%b off=%0d data=%h",
                   i - 1, o_valid, o_sob, o_offset, o_data, e.v, e.sob, e.off, e.data);
        end
      end
    end
  endtask

  task automatic test_positive();
    exp_t e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 4) step(1'b1, 16'h00F0, 16'h00F0, i == 0, 3'd0, 10'h004, 10'h004);
      else if (i < 8) step(1'b1, 16'h00F0, 16'h00F0, i == 4, 3'd6, 10'h0F0, 10'h0F0);
      else step(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 10'h0, 10'h0);
      if (q.size() > 1) begin
        e = q.pop_front();
        compared++;
        if (o_valid !== e.v || o_sob !== e.sob || (e.v && {o_offset, o_data} !== {e.off, e.data})) begin
          mismatched++;
          $display("FAIL positive beat %0d: got v=%b sob=%b off=%0d data=%h want v=%b sob=%b off=%0d data=%h",
                   i - 1, o_valid, o_sob, o_offset, o_data, e.v, e.sob, e.off, e.data);
        end
      end
    end
  endtask

  task automatic test_negative();
    exp_t e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 4) step(1'b1, 16'hFF00, 16'h0004, i == 0, 3'd0, 10'h3FC, 10'h000);
      else if (i < 8) step(1'b1, 16'hFF00, 16'h0004, i == 4, 3'd6, 10'h300, 10'h004);
      else step(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 10'h0, 10'h0);
      if (q.size() > 1) begin
        e = q.pop_front();
        compared++;
        if (o_valid !== e.v || o_sob !== e.sob || (e.v && {o_offset, o_data} !== {e.off, e.data})) begin
          mismatched++;
          $display("FAIL negative beat %0d: got v=%b sob=%b off=%0d data=%h want v=%b sob=%b off=%0d data=%h",
                   i - 1, o_valid, o_sob, o_offset, o_data, e.v, e.sob, e.off, e.data);
        end
      end
    end
  endtask

  task automatic test_mixed();
    exp_t e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) step(1'b1, 16'h0001, 16'h0400, 1'b1, 3'd0, 10'h000, 10'h010);
      else if (i < 4) step(1'b1, 16'h0001, 16'h0001, 1'b0, 3'd0, 10'h000, 10'h000);
      else if (i < 8) step(1'b1, 16'h0001, 16'h0400, i == 4, 3'd4, 10'h000, 10'h100);
      else step(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 10'h0, 10'h0);
      if (q.size() > 1) begin
        e = q.pop_front();
        compared++;
        if (o_valid !== e.v || o_sob !== e.sob || (e.v && {o_offset, o_data} !== {e.off, e.data})) begin
          mismatched++;
          $display("FAIL mixed beat %0d: got v=%b sob=%b off=%0d data=%h want v=%b sob=%b off=%0d data=%h",
                   i - 1, o_valid, o_sob, o_offset, o_data, e.v, e.sob, e.off, e.data);
        end
      end
    end
  endtask

  task automatic test_rounding();
    exp_t e;
    logic [15:0] ra [4] = '{16'h0020, 16'hFFE0, 16'h7FFF, 16'h0000};
    logic [15:0] rb [4] = '{16'h001F, 16'hFFDF, 16'h8000, 16'hFFFF};
    logic [9:0] xa [4] = '{10'h001, 10'h000, 10'h1FF, 10'h000};
    logic [9:0] xb [4] = '{10'h000, 10'h3FF, 10'h200, 10'h000};
    do_reset();
    auto_ena = 1'b0;
    man_offset = 3'd0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) step(1'b1, 16'h0001, 16'h0001, i == 0, 3'd0, 10'h000, 10'h000);
      else if (i < 8) step(1'b1, ra[i-4], rb[i-4], i == 4, 3'd0, xa[i-4], xb[i-4]);
      else step(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 10'h0, 10'h0);
      if (q.size() > 1) begin
        e = q.pop_front();
        compared++;
        if (o_valid !== e.v || o_sob !== e.sob || (e.v && {o_offset, o_data} !== {e.off, e.data})) begin
          mismatched++;
          $display("FAIL rounding beat %0d: got v=%b sob=%b off=%0d data=%h want v=%b sob=%b off=%0d data=%h",
                   i - 1, o_valid, o_sob, o_offset, o_data, e.v, e.sob, e.off, e.data);
        end
      end
    end
  endtask

  task automatic test_stalls();
    exp_t e;
    do_reset();
    auto_ena = 1'b0;
    man_offset = 3'd7;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) step(i % 2 == 0, 16'h0001, 16'h0001, i == 0 || i == 8, i < 8 ? 3'd0 : 3'd6,
                       i < 8 ? 10'h000 : 10'h001, i < 8 ? 10'h000 : 10'h001);
      else step(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 10'h0, 10'h0);
      if (q.size() > 1) begin
        e = q.pop_front();
        compared++;
        if (o_valid !== e.v || o_sob !== e.sob || (e.v && {o_offset, o_data} !== {e.off, e.data})) begin
          mismatched++;
          $display("FAIL stalls cycle %0d: got v=%b sob=%b off=%0d data=%h want v=%b sob=%b off=%0d data=%h",
                   i - 1, o_valid, o_sob, o_offset, o_data, e.v, e.sob, e.off, e.data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(1'b1, 16'h00F0, 16'h00F0, i == 0, 3'd0, 10'h004, 10'h004);
      else step(1'b1, 16'h00F0, 16'h00F0, i == 4, 3'd6, 10'h0F0, 10'h0F0);
      if (q.size() > 1) begin
        e = q.pop_front();
        compared++;
        if (o_valid !== e.v || o_sob !== e.sob || (e.v && {o_offset, o_data} !== {e.off, e.data})) begin
          mismatched++;
          $display("FAIL reset_mid pre beat %0d: got v=%b sob=%b off=%0d data=%h want v=%b sob=%b off=%0d data=%h",
                   i - 1, o_valid, o_sob, o_offset, o_data, e.v, e.sob, e.off, e.data);
        end
      end
    end
    rst = 1'b1;
    i_valid = 1'b0;
    #1;
    compared++;
    if ({o_valid, o_sob, o_offset, o_data} !== 25'h0) begin
      mismatched++;
      $display("FAIL reset_mid async clear: got v=%b sob=%b off=%0d data=%h want all zero", o_valid, o_sob, o_offset, o_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(1'b1, 16'h00F0, 16'h00F0, i == 0, 3'd0, 10'h004, 10'h004);
      else step(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 10'h0, 10'h0);
      if (q.size() > 1) begin
        e = q.pop_front();
        compared++;
        if (o_valid !== e.v || o_sob !== e.sob || (e.v && {o_offset, o_data} !== {e.off, e.data})) begin
          mismatched++;
          $display("FAIL reset_mid post beat %0d: got v=%b sob=%b off=%0d data=%h want v=%b sob=%b off=%0d data=%h",
                   i - 1, o_valid, o_sob, o_offset, o_data, e.v, e.sob, e.off, e.data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_positive();
    test_negative();
    test_mixed();
    test_rounding();
    test_stalls();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
